// File: rtl/img_stream_pkg.sv
// ============================================================================
// Package    : img_stream_pkg
// Description: Shared types and constants for the image stream feeder.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package img_stream_pkg;

    localparam int PIXEL_W  = 8;
    localparam int CREDIT_W = 4;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        WAIT   = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } feeder_state_t;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_skid_buffer.sv
// ============================================================================
// Module     : pixel_skid_buffer
// Description: 2-entry pixel register slice absorbing the 1-clk memory latency.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_skid_buffer
    import img_stream_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_push,
    input  logic [PIXEL_W-1:0] i_data,
    output logic               o_valid,
    output logic [PIXEL_W-1:0] o_data,
    input  logic               i_ready,
    output logic [1:0]         o_occupancy
);

    logic [1:0]         count_q, count_d;
    logic [PIXEL_W-1:0] head_q, head_d;
    logic [PIXEL_W-1:0] tail_q, tail_d;
    logic               pop;

    assign pop     = (count_q != 2'd0) && i_ready;
    assign o_valid = (count_q != 2'd0);
    assign o_data  = head_q;
    // Occupancy left after this cycle's pop, so a draining entry frees its slot at once.
    assign o_occupancy = count_q - {1'b0, pop};

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({i_push, pop})
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = i_data;
                end else begin
                    tail_d = i_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = i_data;
                end else begin
                    head_d = tail_q;
                    tail_d = i_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/image_stream_feeder.sv
// ============================================================================
// Module     : image_stream_feeder
// Description: Line-credit paced frame reader driving an AXI-stream pixel master.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module image_stream_feeder
    import img_stream_pkg::*;
#(
    parameter int LINE_WIDTH    = 512,
    parameter int NUM_LINES     = 512,
    parameter int PREFILL_LINES = 4,
    parameter int ADDR_W        = $clog2(LINE_WIDTH * NUM_LINES)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_intr,
    output logic               o_mem_rd_en,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic [PIXEL_W-1:0] i_mem_data,
    output logic               o_valid,
    output logic [PIXEL_W-1:0] o_data,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int COL_W       = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int LINE_W      = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int GRANT_W     = $clog2(NUM_LINES + 1);
    localparam int PREFILL_EFF = min_int(PREFILL_LINES, NUM_LINES);

    localparam logic [COL_W-1:0]    COL_LAST     = COL_W'(LINE_WIDTH - 1);
    localparam logic [LINE_W-1:0]   LINE_LAST    = LINE_W'(NUM_LINES - 1);
    localparam logic [GRANT_W-1:0]  GRANT_LIMIT  = GRANT_W'(NUM_LINES);
    localparam logic [CREDIT_W-1:0] CREDIT_START = CREDIT_W'(PREFILL_EFF);

    feeder_state_t       state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [GRANT_W-1:0]  grants_q, grants_d;
    logic                inflight_q;

    logic                issue;
    logic                line_end_issue;
    logic                frame_end_issue;
    logic                intr_accept;
    logic                start_accept;
    logic [1:0]          skid_occ;

    pixel_skid_buffer u_skid (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (inflight_q),
        .i_data      (i_mem_data),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_ready     (i_ready),
        .o_occupancy (skid_occ)
    );

    // At most two pixels may be owed to the skid buffer: stored plus in flight.
    assign issue = (state_q == STREAM) && (credits_q != '0) &&
                   ((skid_occ == 2'd0) || ((skid_occ == 2'd1) && !inflight_q));

    assign line_end_issue  = issue && (col_q == COL_LAST);
    assign frame_end_issue = line_end_issue && (line_q == LINE_LAST);
    assign start_accept    = i_start && (state_q == IDLE);

    // A grant is only taken if it can land in the counter, so no line is ever lost.
    assign intr_accept = i_intr &&
                         ((state_q == STREAM) || (state_q == WAIT)) &&
                         (grants_q < GRANT_LIMIT) &&
                         ((credits_q != CREDIT_MAX) || line_end_issue);

    always_comb begin
        credits_d = credits_q;
        grants_d  = grants_q;
        if (start_accept) begin
            credits_d = CREDIT_START;
            grants_d  = GRANT_W'(PREFILL_EFF);
        end else begin
            if (intr_accept) begin
                grants_d = grants_q + 1'b1;
            end
            case ({intr_accept, line_end_issue})
                2'b10:   credits_d = credits_q + 1'b1;
                2'b01:   credits_d = credits_q - 1'b1;
                default: credits_d = credits_q;
            endcase
        end
    end

    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        addr_d = addr_q;
        if (start_accept) begin
            col_d  = '0;
            line_d = '0;
            addr_d = '0;
        end else if (issue) begin
            addr_d = addr_q + 1'b1;
            if (col_q == COL_LAST) begin
                col_d  = '0;
                line_d = line_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_accept) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (frame_end_issue) begin
                    state_d = DRAIN;
                end else if (line_end_issue && (credits_d == '0)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (credits_d != '0) begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                if (!inflight_q && (skid_occ == 2'd0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            line_q     <= '0;
            addr_q     <= '0;
            credits_q  <= '0;
            grants_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            line_q     <= line_d;
            addr_q     <= addr_d;
            credits_q  <= credits_d;
            grants_q   <= grants_d;
            inflight_q <= issue;
        end
    end

    assign o_mem_rd_en = issue;
    assign o_mem_addr  = addr_q;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_image_stream_feeder.sv
// ============================================================================
// Module     : tb_image_stream_feeder
// Description: Scoreboard bench for image_stream_feeder (8x6 frame, 4 prefill lines).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_image_stream_feeder;

    localparam int LW = 8;
    localparam int NL = 6;
    localparam int AW = $clog2(LW * NL);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_intr = 1'b0;
    logic          i_ready = 1'b0;
    logic          o_mem_rd_en;
    logic [AW-1:0] o_mem_addr;
    logic [7:0]    mem_q = 8'd0;
    logic          o_valid;
    logic [7:0]    o_data;
    logic          o_busy;
    logic          o_done;

    int        cyc = 0;
    int        n_checks = 0;
    int        n_fail = 0;
    int        beats = 0;
    int        done_cnt = 0;
    int        done_cyc = 0;
    int        last_acc_cyc = 0;
    int        acc_cyc [64];
    logic [7:0] exp_q[$];
    bit        mon_en = 1'b0;
    bit        prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    image_stream_feeder #(
        .LINE_WIDTH    (LW),
        .NUM_LINES     (NL),
        .PREFILL_LINES (4)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_start     (i_start),
        .i_intr      (i_intr),
        .o_mem_rd_en (o_mem_rd_en),
        .o_mem_addr  (o_mem_addr),
        .i_mem_data  (mem_q),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    // Frame memory model: mem[a] = a[7:0], one clock of read latency.
    always @(posedge clk) begin
        cyc++;
        if (o_mem_rd_en === 1'b1) mem_q <= 8'(o_mem_addr);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                n_checks++;
                if (o_valid !== 1'b1 || o_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b data=%0d, required valid=1 data=%0d", o_valid, o_data, prev_data);
                end
            end
            prev_stall = (o_valid === 1'b1) && !i_ready;
            prev_data  = o_data;
            if (o_valid === 1'b1 && i_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat: got data=%0d, required no beat", o_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (o_data !== e) begin
                        n_fail++;
                        $display("FAIL beat_data[%0d]: got %0d, required %0d", beats, o_data, e);
                    end
                end
                if (beats < 64) acc_cyc[beats] = cyc;
                beats++;
                last_acc_cyc = cyc;
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_q.push_back(8'(i));
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        i_start = 1'b0;
        i_intr = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        beats = 0;
        done_cnt = 0;
        prev_stall = 1'b0;
        mon_en = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic pulse_intr();
        i_intr = 1'b1;
        step();
        i_intr = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beats < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({o_valid, o_data, o_mem_rd_en, o_mem_addr, o_busy, o_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%0d rd_en=%b addr=%0d busy=%b done=%b, required all 0",
                     o_valid, o_data, o_mem_rd_en, o_mem_addr, o_busy, o_done);
        end
        do_reset();
    endtask

    task automatic test_prefill();
        i_ready = 1'b1;
        push_exp(0, 31);
        pulse_start();
        check_int("busy_after_start", int'(o_busy), 1);
        check_int("valid_latency_1", int'(o_valid), 0);
        step();
        check_int("valid_latency_2", int'(o_valid), 0);
        step();
        check_int("valid_latency_3", int'(o_valid), 1);
        check_int("first_data", int'(o_data), 0);
        wait_beats(32, 80);
        repeat (10) step();
        check_int("prefill_beats", beats, 32);
        check_int("prefill_queue_left", exp_q.size(), 0);
        check_int("prefill_full_rate", acc_cyc[31] - acc_cyc[0], 31);
        check_int("wait_valid_low", int'(o_valid), 0);
        check_int("wait_rd_en_low", int'(o_mem_rd_en), 0);
        check_int("wait_busy", int'(o_busy), 1);
    endtask

    task automatic test_lines();
        push_exp(32, 39);
        pulse_intr();
        repeat (19) step();
        check_int("line5_beats", beats, 40);
        check_int("line5_no_done", done_cnt, 0);
        push_exp(40, 47);
        pulse_intr();
        wait_done(60);
        repeat (5) step();
        check_int("frame_beats", beats, 48);
        check_int("frame_done_count", done_cnt, 1);
        check_int("done_after_last_beat", done_cyc - last_acc_cyc, 1);
        check_int("idle_after_done", int'(o_busy), 0);
    endtask

    task automatic test_random_ready();
        int k = 0;
        do_reset();
        push_exp(0, 47);
        pulse_start();
        while (done_cnt == 0 && k < 600) begin
            i_ready = 1'($urandom_range(0, 1));
            i_intr = (k == 2 || k == 4);
            step();
            k++;
        end
        i_intr = 1'b0;
        i_ready = 1'b1;
        repeat (5) step();
        check_int("rand_beats", beats, 48);
        check_int("rand_queue_left", exp_q.size(), 0);
        check_int("rand_done_count", done_cnt, 1);
    endtask

    task automatic test_coincident_intr();
        int k = 0;
        do_reset();
        i_ready = 1'b1;
        push_exp(0, 39);
        pulse_start();
        while (k < 80 && !(o_mem_rd_en === 1'b1 && o_mem_addr == AW'(31))) begin
            step();
            k++;
        end
        check_int("line_end_issue_seen", int'(k < 80), 1);
        pulse_intr();
        repeat (25) step();
        check_int("coinc_beats", beats, 40);
        check_int("coinc_gap", acc_cyc[32] - acc_cyc[31], 1);
        check_int("coinc_valid_low", int'(o_valid), 0);
        push_exp(40, 47);
        pulse_intr();
        wait_done(60);
        repeat (3) step();
        check_int("coinc_frame_beats", beats, 48);
        check_int("coinc_done_count", done_cnt, 1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_ready = 1'b1;
        push_exp(0, 47);
        pulse_start();
        wait_beats(13, 60);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_int("midreset_valid", int'(o_valid), 0);
        check_int("midreset_busy", int'(o_busy), 0);
        check_int("midreset_rd_en", int'(o_mem_rd_en), 0);
        step();
        rst_n = 1'b1;
        exp_q.delete();
        beats = 0;
        done_cnt = 0;
        prev_stall = 1'b0;
        mon_en = 1'b1;
        step();
        push_exp(0, 31);
        pulse_start();
        wait_beats(32, 80);
        repeat (5) step();
        check_int("restart_beats", beats, 32);
        check_int("restart_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_start_busy();
        int k = 0;
        do_reset();
        i_ready = 1'b1;
        push_exp(0, 47);
        pulse_start();
        repeat (5) step();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            pulse_intr();
            repeat (3) step();
        end
        pulse_start();
        while (o_done !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        check_int("done_seen", int'(o_done === 1'b1), 1);
        pulse_start();
        repeat (10) step();
        check_int("start_at_done_ignored", int'(o_busy), 0);
        check_int("busy_beats", beats, 48);
        check_int("busy_queue_left", exp_q.size(), 0);
        check_int("busy_done_count", done_cnt, 1);
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_lines();
        test_random_ready();
        test_coincident_intr();
        test_reset_mid();
        test_start_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
